// File: rtl/reorder_buffer.sv
// 16-entry reorder buffer: in-order retirement of up to two instructions per cycle.
// Optional ROB_FLUSH_EN adds a flush input that discards all in-flight entries.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int PREG  = 64,
  parameter int PCW   = 32,
  localparam int RW   = $clog2(DEPTH),
  localparam int PW   = $clog2(PREG),
  localparam int CW   = RW + 1
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ROB_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             dispValid1,
  input  logic             dispValid2,
  input  logic [RW-1:0]    dispRobNum1,
  input  logic [RW-1:0]    dispRobNum2,
  input  logic [PW-1:0]    dispDestReg1,
  input  logic [PW-1:0]    dispDestReg2,
  input  logic [PW-1:0]    dispDestRegOld1,
  input  logic [PW-1:0]    dispDestRegOld2,
  input  logic [PCW-1:0]   dispPc1,
  input  logic [PCW-1:0]   dispPc2,
  input  logic             cmplValid1,
  input  logic             cmplValid2,
  input  logic [RW-1:0]    cmplRobNum1,
  input  logic [RW-1:0]    cmplRobNum2,
  output logic [DEPTH-1:0] robFree,
  output logic             retValid1,
  output logic             retValid2,
  output logic [PW-1:0]    retDestRegOld1,
  output logic [PW-1:0]    retDestRegOld2,
  output logic [PCW-1:0]   retPc1,
  output logic [PCW-1:0]   retPc2,
  output logic [PREG-1:0]  retireRegReady,
  output logic             robErr
);

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [PW-1:0]    dest_q [DEPTH];
  logic [PW-1:0]    old_q  [DEPTH];
  logic [PCW-1:0]   pc_q   [DEPTH];
  logic [RW-1:0]    fifo_q [DEPTH];
  logic [RW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic             ret_v1_q, ret_v2_q;
  logic [PW-1:0]    ret_old1_q, ret_old2_q;
  logic [PCW-1:0]   ret_pc1_q, ret_pc2_q;
  logic [PREG-1:0]  ready_q, ready_d;

  logic             flush_w;
  logic [RW-1:0]    head_idx, nxt_idx, push2_ptr;
  logic             ret1, ret2;
  logic             acc1_raw, acc2_raw, acc1, acc2, same_slot;
  logic             cmpl_ok1, cmpl_ok2;
  logic [1:0]       n_ret, n_push;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    head_idx  = fifo_q[head_q];
    nxt_idx   = fifo_q[head_q + RW'(1)];
    ret1      = !flush_w && (count_q != '0) && valid_q[head_idx] && done_q[head_idx];
    ret2      = ret1 && (count_q > CW'(1)) && valid_q[nxt_idx] && done_q[nxt_idx];

    // Occupancy is judged on registered state, so an entry retiring this edge is still busy.
    same_slot = dispValid1 && (dispRobNum1 == dispRobNum2);
    acc1_raw  = dispValid1 && !valid_q[dispRobNum1];
    acc2_raw  = dispValid2 && !valid_q[dispRobNum2] && !same_slot;
    cmpl_ok1  = cmplValid1 && valid_q[cmplRobNum1];
    cmpl_ok2  = cmplValid2 && valid_q[cmplRobNum2];
    err_d     = err_q | (dispValid1 & ~acc1_raw) | (dispValid2 & ~acc2_raw)
              | (cmplValid1 & ~cmpl_ok1) | (cmplValid2 & ~cmpl_ok2);
    acc1      = acc1_raw && !flush_w;
    acc2      = acc2_raw && !flush_w;

    n_ret     = {1'b0, ret1} + {1'b0, ret2};
    n_push    = {1'b0, acc1} + {1'b0, acc2};
    push2_ptr = acc1 ? tail_q + RW'(1) : tail_q;

    valid_d = valid_q;
    done_d  = done_q;
    if (cmpl_ok1) done_d[cmplRobNum1] = 1'b1;
    if (cmpl_ok2) done_d[cmplRobNum2] = 1'b1;
    if (ret1) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
    end
    if (ret2) begin
      valid_d[nxt_idx] = 1'b0;
      done_d[nxt_idx]  = 1'b0;
    end
    if (acc1) begin
      valid_d[dispRobNum1] = 1'b1;
      done_d[dispRobNum1]  = 1'b0;
    end
    if (acc2) begin
      valid_d[dispRobNum2] = 1'b1;
      done_d[dispRobNum2]  = 1'b0;
    end

    head_d  = head_q + RW'(n_ret);
    tail_d  = tail_q + RW'(n_push);
    count_d = count_q + CW'(n_push) - CW'(n_ret);

    ready_d = '0;
    if (ret1) ready_d[dest_q[head_idx]] = 1'b1;
    if (ret2) ready_d[dest_q[nxt_idx]]  = 1'b1;

    if (flush_w) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      done_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      ret_v1_q   <= 1'b0;
      ret_v2_q   <= 1'b0;
      ret_old1_q <= '0;
      ret_old2_q <= '0;
      ret_pc1_q  <= '0;
      ret_pc2_q  <= '0;
      ready_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      err_q    <= err_d;
      ret_v1_q <= ret1;
      ret_v2_q <= ret2;
      ready_q  <= ready_d;
      if (ret1) begin
        ret_old1_q <= old_q[head_idx];
        ret_pc1_q  <= pc_q[head_idx];
      end
      if (ret2) begin
        ret_old2_q <= old_q[nxt_idx];
        ret_pc2_q  <= pc_q[nxt_idx];
      end
    end
  end

  // Payload storage is only read behind valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (acc1) begin
      dest_q[dispRobNum1] <= dispDestReg1;
      old_q[dispRobNum1]  <= dispDestRegOld1;
      pc_q[dispRobNum1]   <= dispPc1;
      fifo_q[tail_q]      <= dispRobNum1;
    end
    if (acc2) begin
      dest_q[dispRobNum2] <= dispDestReg2;
      old_q[dispRobNum2]  <= dispDestRegOld2;
      pc_q[dispRobNum2]   <= dispPc2;
      fifo_q[push2_ptr]   <= dispRobNum2;
    end
  end

  assign robFree        = ~valid_q;
  assign retValid1      = ret_v1_q;
  assign retValid2      = ret_v2_q;
  assign retDestRegOld1 = ret_old1_q;
  assign retDestRegOld2 = ret_old2_q;
  assign retPc1         = ret_pc1_q;
  assign retPc2         = ret_pc2_q;
  assign retireRegReady = ready_q;
  assign robErr         = err_q;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry reorder buffer; the receiving end of the reservation station's ROB dispatch interface.
- Accepts up to two dispatched instructions per cycle into the slots named by the dispatcher, and publishes its free-slot bitmap back to it.
- Records completion per slot and retires up to two instructions per cycle in program (dispatch) order.
- Retirement marks destination registers ready and releases old destination registers.

Parameters:
- DEPTH, 16, ROB entries; robNum width is log2(DEPTH) = 4.
- PREG, 64, physical registers; register index width is 6.
- PCW, 32, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dispValid1 / dispValid2  in  1  dispatch slot 1 / slot 2 valid (slot 1 is older)
- dispRobNum1 / dispRobNum2  in  4  target ROB entry
- dispDestReg1 / dispDestReg2  in  6  new physical destination
- dispDestRegOld1 / dispDestRegOld2  in  6  previous physical mapping of rd
- dispPc1 / dispPc2  in  32  instruction PC
- cmplValid1 / cmplValid2  in  1  completion valid
- cmplRobNum1 / cmplRobNum2  in  4  completed entry
- robFree  out  16  bit i = 1 when entry i is unallocated
- retValid1 / retValid2  out  1  retire pulse; retValid2 only when retValid1
- retDestRegOld1 / retDestRegOld2  out  6  register returned to the free list
- retPc1 / retPc2  out  32  PC of the retired instruction
- retireRegReady  out  64  one-hot OR of retiring dispDestReg values, 1-cycle pulse
- robErr  out  1  sticky protocol-violation flag
- flush  in  1  present only with ROB_FLUSH_EN

Behaviour:
- Per-entry state: valid, done, destReg, destRegOld, pc.
- Order FIFO: 16 x 4-bit entry indices with head/tail pointers (wrap mod 16) and a 5-bit count. Records dispatch order.
- Reset, registered:
  - robFree = 16'hFFFF.
  - All valid/done = 0; FIFO empty.
  - All ret* outputs and retireRegReady = 0; robErr = 0.
- Dispatch, edge N:
  - Each valid slot writes its entry: valid = 1, done = 0.
  - Order FIFO pushes slot 1 then slot 2. If only slot 2 is valid, it is pushed alone.
  - robFree bit clears, visible after edge N.
- Completion, edge N: sets done on the named entry if it is valid. Otherwise ignored and robErr is set.
- Retire decision: made from registered state each cycle.
  - Head entry valid and done -> retire it.
  - If additionally the head+1 entry is valid and done -> retire it too.
  - Never skip an incomplete head.
- Retire timing: if done is set at edge N, the retire outputs pulse for the cycle after edge N+1. The entry is freed at edge N+1, and its robFree bit is 1 after edge N+1.
- Retire outputs are registered single-cycle pulses. Data outputs hold their last value when not valid.
- Simultaneous events at one edge:
  - Retire-free and dispatch to a different slot: both happen.
  - Dispatch to an entry that robFree showed as occupied (including one retiring this edge): rejected, robErr = 1.
  - Completion arriving on the same edge as dispatch to the same entry: rejected (entry not yet valid).
- dispRobNum1 == dispRobNum2 with both valid: accept slot 1, drop slot 2, robErr = 1.
- cmplRobNum1 == cmplRobNum2: legal, idempotent.
- Full (count = 16): robFree = 0; any dispatch sets robErr and is dropped.
- Empty: no retire.
- Pointer and count arithmetic wraps modulo 16 and 32 respectively.
- Reset mid-operation: all in-flight entries are discarded. No retire pulse is emitted in the reset cycle or the cycle after.

Optional Feature:
ROB_FLUSH_EN
- Defined: adds the flush input. flush = 1 at edge N:
  - clears all valid/done;
  - empties the FIFO;
  - sets robFree = 16'hFFFF;
  - suppresses the retire and dispatch writes at that edge;
  - retire outputs are 0 in the following cycle.
- robErr is unaffected by flush.
- Undefined: no flush port; the buffer is cleared only by reset.

Test Plan:
1. Reset -> robFree = 16'hFFFF, retValid1/2 = 0, robErr = 0.
2. Dispatch to entry 15 (pc 0x100) and entry 14 (pc 0x104), then complete 14 -> no retire. Then complete 15 -> next cycle retValid1 = 1, retPc1 = 0x100; retValid2 = 1, retPc2 = 0x104; robFree = 16'hFFFF.
3. Dispatch entry 3 (destReg 40, destRegOld 7), complete it -> retireRegReady = 64'h1 << 40 for one cycle; retDestRegOld1 = 7.
4. Fill all 16 entries, then dispatch entry 0 again -> robErr = 1, robFree unchanged at 0. Then complete all 16 -> eight consecutive dual-retire cycles, in dispatch order.
5. dispRobNum1 = dispRobNum2 = 5, both valid -> only slot-1 data stored in entry 5; robErr = 1.
6. With ROB_FLUSH_EN: five entries valid, 2 done, flush asserted -> next cycle robFree = 16'hFFFF with no retire pulse. A subsequent dispatch and complete retires normally.
